// File: rtl/ws2812b_multi_pkg.sv
// ws2812b_multi_pkg: register map, CTRL/status bit positions, controller states and default bit timing
// Ports: none (package).
package ws2812b_multi_pkg;
    localparam logic [3:0] A_CTRL    = 4'h0;
    localparam logic [3:0] A_G       = 4'h1;
    localparam logic [3:0] A_R       = 4'h2;
    localparam logic [3:0] A_B       = 4'h3;
    localparam logic [3:0] A_W       = 4'h4;
    localparam logic [3:0] A_COUNT_L = 4'h5;
    localparam logic [3:0] A_COUNT_H = 4'h6;
    localparam logic [3:0] A_CHMASK  = 4'h7;
    localparam logic [3:0] A_DG      = 4'h8;
    localparam logic [3:0] A_DR      = 4'h9;
    localparam logic [3:0] A_DB      = 4'hA;

    localparam int C_START = 0;
    localparam int C_LATCH = 1;
    localparam int C_BLACK = 2;

    localparam int S_READY    = 0;
    localparam int S_BUSY     = 1;
    localparam int S_LATCHING = 2;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;

    localparam int DEF_T0H  = 26;
    localparam int DEF_T1H  = 51;
    localparam int DEF_TBIT = 80;
    localparam int DEF_TRES = 3200;
endpackage

// File: rtl/ws2812b_serializer.sv
// ws2812b_serializer: shifts one pixel word MSB first as WS2812B bit periods, or holds a latch low time
// Ports: clk, rst_n (async, active low); word/valid load a pixel, latch starts a reset pulse,
//        both accepted only while ready; led is the serial data line.
module ws2812b_serializer import ws2812b_multi_pkg::*; #(
    parameter int PIX_BITS = 24,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRES     = DEF_TRES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PIX_BITS-1:0] word,
    input  logic                valid,
    input  logic                latch,
    output logic                ready,
    output logic                led
);
    localparam int TW = $clog2(TRES > TBIT ? TRES : TBIT);
    localparam int BW = $clog2(PIX_BITS);
    localparam logic [TW-1:0] T_BIT_END = TW'(TBIT - 1);
    localparam logic [TW-1:0] T_RES_END = TW'(TRES - 1);
    localparam logic [TW-1:0] T_HI1     = TW'(T1H);
    localparam logic [TW-1:0] T_HI0     = TW'(T0H);
    localparam logic [BW-1:0] B_END     = BW'(PIX_BITS - 1);

    logic                act, lat;
    logic [PIX_BITS-1:0] sr;
    logic [BW-1:0]       bcnt;
    logic [TW-1:0]       tcnt;
    logic                bit_end;

    assign bit_end = act && tcnt == T_BIT_END;
    // ready also covers the final clock of a word, so the next word follows without a gap
    assign ready = act ? (bcnt == B_END && tcnt == T_BIT_END) : (!lat || tcnt == T_RES_END);
    assign led   = act && tcnt < (sr[PIX_BITS-1] ? T_HI1 : T_HI0);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            act  <= 1'b0;
            lat  <= 1'b0;
            sr   <= '0;
            bcnt <= '0;
            tcnt <= '0;
        end else if (ready) begin
            act  <= valid;
            lat  <= !valid && latch;
            sr   <= word;
            bcnt <= '0;
            tcnt <= '0;
        end else begin
            tcnt <= bit_end ? '0 : tcnt + 1'b1;
            if (bit_end) begin
                sr   <= sr << 1;
                bcnt <= bcnt + 1'b1;
            end
        end
endmodule

// File: rtl/tqvp_cattuto_ws2812b_multi.sv
// tqvp_cattuto_ws2812b_multi: TinyQV byte peripheral streaming one colour to up to NUM_CH WS2812B strips
// Ports: clk, rst_n (async, active low); ui_in unused; uo_out[NUM_CH:1] strip data, other bits 0;
//        address/data_write/data_in register writes; data_out combinational register read.
// Optional: define WS2812B_MULTI_GRADIENT_EN for per-pixel colour deltas at 0x8-0xA.
module tqvp_cattuto_ws2812b_multi import ws2812b_multi_pkg::*; #(
    parameter int NUM_CH   = 4,
    parameter int PIX_BITS = 24,
    parameter int COUNT_W  = 16,
    parameter int T0H      = DEF_T0H,
    parameter int T1H      = DEF_T1H,
    parameter int TBIT     = DEF_TBIT,
    parameter int TRES     = DEF_TRES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    state_t              state, state_n;
    logic [7:0]          g, r, b, w, cg, cr, cb;
    logic [COUNT_W-1:0]  count, cnt;
    logic [NUM_CH-1:0]   chmask;
    logic [15:0]         count16;
    logic [31:0]         full;
    logic [PIX_BITS-1:0] ser_word;
    logic                lat_after, black, busy, wr_ctrl, start, last_pix;
    logic                ser_ready, ser_valid, ser_latch, led, unused_ok;

    assign count16   = 16'(count);
    assign busy      = state != IDLE;
    assign wr_ctrl   = data_write && address == A_CTRL;
    assign start     = wr_ctrl && data_in[C_START] && !busy;
    assign last_pix  = cnt == COUNT_W'(1);
    assign full      = {cg, cr, cb, w};
    assign ser_word  = black ? '0 : full[31 -: PIX_BITS];
    // the next pixel is handed over on the last clock of the current one
    assign ser_valid = state == LOAD || (state == SEND && ser_ready && !last_pix);
    assign ser_latch = (start && count == '0 && data_in[C_LATCH]) ||
                       (state == SEND && ser_ready && last_pix && lat_after);
    assign uo_out    = 8'({{NUM_CH{led}} & chmask, 1'b0});
    assign unused_ok = ^{ui_in, full};

    assign state_n = state == IDLE ? (start ? (count != '0 ? LOAD : data_in[C_LATCH] ? LATCH : IDLE) : IDLE)
                   : state == LOAD ? SEND
                   : !ser_ready ? state
                   : state == SEND && !last_pix ? SEND
                   : state == SEND && lat_after ? LATCH : IDLE;

`ifdef WS2812B_MULTI_GRADIENT_EN
    logic [7:0] dg, dr, db, wg, wr, wb;
    // during SEND the colour offered is that of the following pixel
    assign {cg, cr, cb} = state == SEND ? {wg + dg, wr + dr, wb + db} : {wg, wr, wb};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {dg, dr, db} <= '0;
            {wg, wr, wb} <= '0;
        end else begin
            if (data_write && address == A_DG) dg <= data_in;
            if (data_write && address == A_DR) dr <= data_in;
            if (data_write && address == A_DB) db <= data_in;
            if (start) {wg, wr, wb} <= {g, r, b};
            else if (state == SEND && ser_ready) {wg, wr, wb} <= {cg, cr, cb};
        end
`else
    assign {cg, cr, cb} = {g, r, b};
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            {g, r, b} <= '0;
            w         <= '0;
            count     <= '0;
            cnt       <= '0;
            chmask    <= '1;
            lat_after <= 1'b0;
            black     <= 1'b0;
        end else begin
            if (data_write && address == A_G) g <= data_in;
            if (data_write && address == A_R) r <= data_in;
            if (data_write && address == A_B) b <= data_in;
            if (data_write && address == A_W && PIX_BITS == 32) w <= data_in;
            if (data_write && address == A_COUNT_L && !busy) count <= COUNT_W'({count16[15:8], data_in});
            if (data_write && address == A_COUNT_H && !busy) count <= COUNT_W'({data_in, count16[7:0]});
            if (data_write && address == A_CHMASK && !busy) chmask <= data_in[NUM_CH-1:0];
            if (start) begin
                cnt       <= count;
                lat_after <= data_in[C_LATCH];
                black     <= data_in[C_BLACK];
            end
            if (state == SEND && ser_ready) cnt <= cnt - 1'b1;
            state <= state_n;
        end

    always_comb
        case (address)
            A_CTRL:    data_out = {5'b0, state == LATCH, busy, !busy && !(wr_ctrl && data_in[C_START])};
            A_G:       data_out = g;
            A_R:       data_out = r;
            A_B:       data_out = b;
            A_W:       data_out = w;
            A_COUNT_L: data_out = count16[7:0];
            A_COUNT_H: data_out = count16[15:8];
            A_CHMASK:  data_out = 8'(chmask);
`ifdef WS2812B_MULTI_GRADIENT_EN
            A_DG:      data_out = dg;
            A_DR:      data_out = dr;
            A_DB:      data_out = db;
`endif
            default:   data_out = 8'h00;
        endcase

    ws2812b_serializer #(
        .PIX_BITS(PIX_BITS), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRES(TRES)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .word  (ser_word),
        .valid (ser_valid),
        .latch (ser_latch),
        .ready (ser_ready),
        .led   (led)
    );
endmodule
